// File: rtl/mc_pkg.sv
// +--------------------------------------------------------------------+
// | mc_pkg: state, ALU-op and opcode encodings for multicycle_controller |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// +--------------------------------------------------------------------+
// | alu_decoder: maps aluop/funct3/funct7 to the 3-bit ALU control code  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          // sltu has no unsigned compare path and runs as signed slt
          3'b010,
          3'b011:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = ALU_SRA;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// +--------------------------------------------------------------------+
// | multicycle_controller: Moore FSM control unit for multicycle RV32I   |
// | Optional macro MC_BNE_EN adds bne (funct3=001) branch support.       |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcupdate, branch, taken;
  logic   irwrite_raw, regwrite_raw, memwrite_raw;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = FETCH;
    aluop        = ALUOP_ADD;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    case (state_q)
      FETCH: begin
        state_d     = DECODE;
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BR:        state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: begin
        state_d = MEMWB;
        adrsrc  = 1'b1;
      end
      MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: regwrite_raw = 1'b1;
      JAL: begin
        state_d  = ALUWB;
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

`ifdef MC_BNE_EN
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end
`else
  assign taken = zero;
`endif

  // Enables are held off while reset is low so an abandoned instruction never writes
  assign pcwrite  = reset & (pcupdate | (branch & taken));
  assign irwrite  = reset & irwrite_raw;
  assign regwrite = reset & regwrite_raw;
  assign memwrite = reset & memwrite_raw;

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BR:   immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// +--------------------------------------------------------------------+
// | tb_multicycle_controller: scoreboard bench with a reference model    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  typedef state_t sseq_t[$];

  exp_t scb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: the sequence of states an opcode walks through, FETCH first
  function automatic sseq_t path(input logic [6:0] o);
    sseq_t p;
    p.push_back(FETCH);
    p.push_back(DECODE);
    case (o)
      7'b0000011: begin p.push_back(MEMADR); p.push_back(MEMREAD); p.push_back(MEMWB); end
      7'b0100011: begin p.push_back(MEMADR); p.push_back(MEMWRITE); end
      7'b0110011: begin p.push_back(EXECUTER); p.push_back(ALUWB); end
      7'b0010011: begin p.push_back(EXECUTEI); p.push_back(ALUWB); end
      7'b1101111: begin p.push_back(JAL); p.push_back(ALUWB); end
      7'b1100011: p.push_back(BEQ);
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z);
`ifdef MC_BNE_EN
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return ~z;
    return 1'b0;
`else
    return z;
`endif
  endfunction

  // Reference: control word {pcw,adr,mw,irw,rw,rs,sa,sb,imm,alu}
  function automatic logic [15:0] model_ctl(input state_t s, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z, input logic in_rst);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sbs, imm;
    logic [2:0] alu;
    int         aop;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sbs = 0; aop = 0;
    case (s)
      FETCH:    begin irw = 1; sbs = 2; rs = 2; pcw = 1; end
      DECODE:   begin sa = 1; sbs = 1; end
      MEMADR:   begin sa = 2; sbs = 1; end
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 1; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECUTER: begin sa = 2; aop = 2; end
      EXECUTEI: begin sa = 2; sbs = 1; aop = 2; end
      ALUWB:    rw = 1;
      JAL:      begin sa = 1; sbs = 2; pcw = 1; end
      BEQ:      begin sa = 2; aop = 1; pcw = br_taken(f3, z); end
      default: ;
    endcase
    if (o == 7'b0100011)      imm = 2'd1;
    else if (o == 7'b1100011) imm = 2'd2;
    else if (o == 7'b1101111) imm = 2'd3;
    else                      imm = 2'd0;
    if (aop == 0)      alu = 3'd0;
    else if (aop == 1) alu = 3'd1;
    else begin
      case (f3)
        3'd0: alu = (o[5] & f7) ? 3'd1 : 3'd0;
        3'd1: alu = 3'd6;
        3'd2: alu = 3'd5;
        3'd3: alu = 3'd5;
        3'd4: alu = 3'd4;
        3'd5: alu = 3'd7;
        3'd6: alu = 3'd3;
        default: alu = 3'd2;
      endcase
    end
    if (in_rst) begin pcw = 0; mw = 0; irw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rw, rs, sa, sbs, imm, alu};
  endfunction

  task automatic push(input state_t s, input logic in_rst);
    exp_t e;
    e.st  = s;
    e.ctl = model_ctl(s, op, funct3, funct7b5, zero, in_rst);
    scb.push_back(e);
  endtask

  // One instruction; abort_at >= 0 asserts reset in that cycle for 'hold' cycles
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
      input logic z, input int abort_at, input int hold);
    sseq_t p;
    p = path(o);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    foreach (p[i]) begin
      if (i == abort_at) begin
        reset = 1'b0;
        push(p[i], 1'b1);
        @(posedge clk); #1;
        for (int h = 1; h < hold; h++) begin
          push(FETCH, 1'b1);
          @(posedge clk); #1;
        end
        reset = 1'b1;
        return;
      end
      push(p[i], 1'b0);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (scb.size() > 0) begin
      e = scb.pop_front();
      n_cmp++;
      if (state !== e.st) begin
        n_err++;
        $display("FAIL state: got %0d expected %0d at %0t", state, e.st, $time);
      end
      n_cmp++;
      if ({pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb,
           immsrc, alucontrol} !== e.ctl) begin
        n_err++;
        $display("FAIL ctl (state %0d): got %b expected %b at %0t",
                 state, {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                 alusrca, alusrcb, immsrc, alucontrol}, e.ctl, $time);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

  localparam logic [6:0] OPS [0:6] = '{7'b0000011, 7'b0100011, 7'b0110011,
      7'b0010011, 7'b1101111, 7'b1100011, 7'b0110111};

  initial begin
    logic [6:0] o;
    int         ab, len, sel;
    reset = 1'b0; op = 7'b0110011; funct3 = 3'd5; funct7b5 = 1'b1; zero = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      push(FETCH, 1'b1);
      @(posedge clk); #1;
    end
    reset = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 0);  // lw
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1, 0);  // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, -1, 0);  // addi
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, -1, 0);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0);  // beq not taken
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, -1, 0);  // bne, zero=0
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, -1, 0);  // bne, zero=1
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, -1, 0);  // unsupported opcode
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, -1, 0);  // sw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3, 2);   // reset in MEMWRITE
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, -1, 0);  // jal
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 3);   // reset in MEMADR

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      o   = (sel == 7) ? 7'($urandom) : OPS[sel];
      len = path(o).size();
      ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), ab, $urandom_range(1, 3));
    end

    repeat (2) @(negedge clk);
    n_cmp++;
    if (scb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I datapath. It sits directly upstream of the ALU and drives `alucontrol`, the ALU source selects and every datapath enable from a Moore state machine. Its inputs are the fetched instruction fields and the ALU `zero` flag. It sequences fetch, decode, execute, memory and writeback so that each instruction takes 3–5 cycles.

## Interface
Parameters: none; all encodings come from `mc_pkg`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge forces FETCH.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU `zero` flag for the current cycle.
- `pcwrite`  out  1  PC register enable.
- `adrsrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  data memory write strobe.
- `irwrite`  out  1  instruction/OldPC register enable.
- `regwrite`  out  1  register file write enable.
- `resultsrc`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `alusrca`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `alusrcb`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `immsrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alucontrol`  out  3  ALU operation code.
- `state`  out  4  current state, for debug and the bench.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL. The state register resets to FETCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE goes by `op`:
    - 0000011 (lw) or 0100011 (sw)→MEMADR.
    - 0110011→EXECUTER.
    - 0010011→EXECUTEI.
    - 1101111→JAL.
    - 1100011→BEQ.
    - any other opcode→FETCH; it is treated as a no-op with no writes.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI and JAL→ALUWB→FETCH.
  - BEQ→FETCH.
- **Per-state outputs:** any output not listed below is 0 or 00.
  - FETCH: `irwrite`=1, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10, `pcupdate`=1.
  - DECODE: `alusrca`=01, `alusrcb`=01, `aluop`=00 (branch/jump target).
  - MEMADR: `alusrca`=10, `alusrcb`=01, `aluop`=00.
  - MEMREAD: `adrsrc`=1.
  - MEMWB: `resultsrc`=01, `regwrite`=1.
  - MEMWRITE: `adrsrc`=1, `memwrite`=1.
  - EXECUTER: `alusrca`=10, `alusrcb`=00, `aluop`=10.
  - EXECUTEI: `alusrca`=10, `alusrcb`=01, `aluop`=10.
  - ALUWB: `regwrite`=1.
  - JAL: `alusrca`=01, `alusrcb`=10, `aluop`=00, `pcupdate`=1.
  - BEQ: `alusrca`=10, `alusrcb`=00, `aluop`=01, `branch`=1.
- **PC enable:** `pcwrite` = `pcupdate` | (`branch` & `taken`), where `taken` = `zero`.
- **`immsrc`:** combinational from `op`:
  - lw and I-ALU→00.
  - sw→01.
  - branch→10.
  - jal→11.
  - any other opcode→00.
- **ALU decode:**
  - `aluop` 00→000 (add).
  - `aluop` 01→001 (sub).
  - `aluop` 10 decodes by `funct3`:
    - 000→001 if `op[5]`&`funct7b5`, else 000.
    - 001→110 (sll).
    - 010→101 (slt, signed).
    - 011→101 (sltu is not supported and executes as signed slt).
    - 100→100 (xor).
    - 101→111 (sra, independent of `funct7b5`).
    - 110→011 (or).
    - 111→010 (and).

## Timing
- Outputs are combinational from `state` and the instruction inputs. There is no output register.
- While `reset`==0, `pcwrite`, `irwrite`, `regwrite` and `memwrite` are forced to 0. `state` reads FETCH from the first reset edge onward.
- Reset asserted mid-instruction abandons the instruction. The next edge loads FETCH, and no partial write occurs after the reset edge.
- Cycles per instruction: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal opcode 2.
- `zero` is sampled combinationally in BEQ. The PC updates at the end of BEQ only if the branch is taken.

## Configuration
- **`MC_BNE_EN` defined:**
  - In BEQ, `taken` = `zero` when `funct3`=000 and `taken` = ~`zero` when `funct3`=001.
  - Any other `funct3` gives `taken`=0.
- **`MC_BNE_EN` undefined:** `funct3` is ignored in BEQ and `taken` = `zero` for every branch.

## Structure
- **`mc_pkg`:**
  - `state_t` enum, 4 bits.
  - `aluop_t` (2 bits).
  - ALU code localparams: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_SLT=101, ALU_SLL=110, ALU_SRA=111.
  - Opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR.
- **Sub-module `alu_decoder`:** purely combinational, inputs `aluop`, `funct3`, `op5` and `funct7b5`; output `alucontrol`.
- The state machine, `immsrc` decode and enable gating stay in the top module.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles from an arbitrary state → `state`=FETCH; `pcwrite`, `regwrite`, `memwrite` and `irwrite` are all 0 while reset is held.
- **lw:** `op`=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. `regwrite`=1 only in MEMWB with `resultsrc`=01, and `adrsrc`=1 in MEMREAD.
- **sub:** `op`=0110011, `funct3`=000, `funct7b5`=1 → `alucontrol`=001 in EXECUTER, then ALUWB with `regwrite`=1. The same instruction with `op`=0010011 (addi) gives `alucontrol`=000.
- **beq:** `op`=1100011 with `zero`=1 in BEQ → `pcwrite`=1 and `alucontrol`=001. With `zero`=0 → `pcwrite`=0. Both paths return to FETCH after 3 cycles.
- **bne (`MC_BNE_EN` only):** `funct3`=001 with `zero`=0 → `pcwrite`=1; with `zero`=1 → `pcwrite`=0.
- **Illegal opcode and mid-instruction reset:**
  - `op`=0110111 → DECODE returns to FETCH and no enable other than FETCH's fires.
  - `reset`=0 in MEMWRITE → `memwrite`=0 that cycle and `state`=FETCH at the next edge.
